// File: rtl/noc_leaf_ni.sv
`default_nettype none
// ============================================================================
//  Module      : noc_leaf_ni
//  Description : Leaf network interface between one PE and a NoC router port.
//                TX packs PE requests into sender-stamped packets in a FIFO.
//                RX filters router packets by receiver address into a FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_leaf_ni #(
  parameter int NODE_ADDR  = 2,
  parameter int WIDTH_pack = 18,
  parameter int WIDTH_add  = 4,
  parameter int WIDTH_type = 2,
  parameter int WIDTH_data = 8,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_tx_valid,
  output logic                  pe_tx_ready,
  input  logic [WIDTH_add-1:0]  pe_tx_dest,
  input  logic [WIDTH_type-1:0] pe_tx_type,
  input  logic [WIDTH_data-1:0] pe_tx_data,
  output logic                  net_tx_valid,
  input  logic                  net_tx_ready,
  output logic [WIDTH_pack-1:0] net_tx_pack,
  input  logic                  net_rx_valid,
  output logic                  net_rx_ready,
  input  logic [WIDTH_pack-1:0] net_rx_pack,
  output logic                  pe_rx_valid,
  input  logic                  pe_rx_ready,
  output logic [WIDTH_add-1:0]  pe_rx_src,
  output logic [WIDTH_type-1:0] pe_rx_type,
  output logic [WIDTH_data-1:0] pe_rx_data,
  output logic                  err_misroute,
  output logic                  err_self,
  output logic [7:0]            drop_cnt
);

  localparam int RX_W   = WIDTH_add + WIDTH_type + WIDTH_data;
  localparam int LO_W   = WIDTH_type + WIDTH_data;
  localparam int RCV_LSB = LO_W;
  localparam int SND_LSB = LO_W + WIDTH_add;
  localparam int TX_AW  = $clog2(TX_DEPTH);
  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int TX_CW  = $clog2(TX_DEPTH + 1);
  localparam int RX_CW  = $clog2(RX_DEPTH + 1);
  localparam logic [WIDTH_add-1:0] MY_ADDR = WIDTH_add'(NODE_ADDR);
  localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
  localparam logic [TX_AW-1:0] TX_LAST = TX_AW'(TX_DEPTH - 1);
  localparam logic [RX_AW-1:0] RX_LAST = RX_AW'(RX_DEPTH - 1);

  logic                  up_q;
  logic [WIDTH_pack-1:0] tx_mem_q [TX_DEPTH];
  logic [RX_W-1:0]       rx_mem_q [RX_DEPTH];
  logic [TX_AW-1:0]      tx_head_q, tx_tail_q;
  logic [RX_AW-1:0]      rx_head_q, rx_tail_q;
  logic [TX_CW-1:0]      tx_cnt_q;
  logic [RX_CW-1:0]      rx_cnt_q;
  logic                  err_self_q, err_mis_q;
  logic [7:0]            drop_q, drop_d;
  logic [8:0]            drop_sum;

  logic tx_hs, tx_self, tx_push, tx_pop;
  logic rx_hs, rx_drop, rx_push, rx_pop;
  logic [RX_W-1:0] rx_head_entry;

  // Readys are held low until the first clock edge after reset release, so
  // they never depend on the inputs and rise one cycle after rst_n goes high.
  assign pe_tx_ready  = up_q && (tx_cnt_q != TX_FULL);
  assign net_rx_ready = up_q && (rx_cnt_q != RX_FULL);
  assign net_tx_valid = (tx_cnt_q != '0);
  assign pe_rx_valid  = (rx_cnt_q != '0);

  // Empty FIFOs present zeros rather than whatever stale entry sits at head.
  assign net_tx_pack   = net_tx_valid ? tx_mem_q[tx_head_q] : '0;
  assign rx_head_entry = pe_rx_valid ? rx_mem_q[rx_head_q] : '0;
  assign pe_rx_src     = rx_head_entry[RX_W-1 -: WIDTH_add];
  assign pe_rx_type    = rx_head_entry[LO_W-1 -: WIDTH_type];
  assign pe_rx_data    = rx_head_entry[WIDTH_data-1:0];

  assign tx_hs   = pe_tx_valid && pe_tx_ready;
  assign tx_self = tx_hs && (pe_tx_dest == MY_ADDR);
  assign tx_push = tx_hs && !tx_self;
  assign tx_pop  = net_tx_valid && net_tx_ready;

  assign rx_hs   = net_rx_valid && net_rx_ready;
  assign rx_drop = rx_hs && (net_rx_pack[RCV_LSB +: WIDTH_add] != MY_ADDR);
  assign rx_push = rx_hs && !rx_drop;
  assign rx_pop  = pe_rx_valid && pe_rx_ready;

  assign err_self     = err_self_q;
  assign err_misroute = err_mis_q;
  assign drop_cnt     = drop_q;

  // A TX and an RX drop may coincide, so the counter can advance by two.
  always_comb begin
    drop_sum = {1'b0, drop_q} + {8'd0, tx_self} + {8'd0, rx_drop};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // FIFO storage is data-only and needs no reset; reads are gated by count.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_tail_q] <= {MY_ADDR, pe_tx_dest, pe_tx_type, pe_tx_data};
    if (rx_push) rx_mem_q[rx_tail_q] <= {net_rx_pack[SND_LSB +: WIDTH_add], net_rx_pack[LO_W-1:0]};
  end

  // Pointers, occupancy counts, sticky errors and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q       <= 1'b0;
      tx_head_q  <= '0;
      tx_tail_q  <= '0;
      tx_cnt_q   <= '0;
      rx_head_q  <= '0;
      rx_tail_q  <= '0;
      rx_cnt_q   <= '0;
      err_self_q <= 1'b0;
      err_mis_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      up_q <= 1'b1;
      if (tx_push) tx_tail_q <= (tx_tail_q == TX_LAST) ? '0 : tx_tail_q + TX_AW'(1);
      if (tx_pop)  tx_head_q <= (tx_head_q == TX_LAST) ? '0 : tx_head_q + TX_AW'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + TX_CW'(1);
      else if (tx_pop && !tx_push) tx_cnt_q <= tx_cnt_q - TX_CW'(1);
      if (rx_push) rx_tail_q <= (rx_tail_q == RX_LAST) ? '0 : rx_tail_q + RX_AW'(1);
      if (rx_pop)  rx_head_q <= (rx_head_q == RX_LAST) ? '0 : rx_head_q + RX_AW'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + RX_CW'(1);
      else if (rx_pop && !rx_push) rx_cnt_q <= rx_cnt_q - RX_CW'(1);
      if (tx_self) err_self_q <= 1'b1;
      if (rx_drop) err_mis_q  <= 1'b1;
      drop_q <= drop_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_leaf_ni.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_leaf_ni
//  Description : Self-checking bench for noc_leaf_ni with a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_leaf_ni;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pe_tx_valid = 1'b0, net_tx_ready = 1'b0, net_rx_valid = 1'b0, pe_rx_ready = 1'b0;
  logic [3:0]  pe_tx_dest = '0;
  logic [1:0]  pe_tx_type = '0;
  logic [7:0]  pe_tx_data = '0;
  logic [17:0] net_rx_pack = '0;
  logic        pe_tx_ready, net_tx_valid, net_rx_ready, pe_rx_valid, err_misroute, err_self;
  logic [17:0] net_tx_pack;
  logic [3:0]  pe_rx_src;
  logic [1:0]  pe_rx_type;
  logic [7:0]  pe_rx_data, drop_cnt;

  int errors = 0;
  int checks = 0;

  noc_leaf_ni #(.NODE_ADDR(2), .WIDTH_pack(18), .WIDTH_add(4), .WIDTH_type(2),
                .WIDTH_data(8), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready), .pe_tx_dest(pe_tx_dest),
    .pe_tx_type(pe_tx_type), .pe_tx_data(pe_tx_data),
    .net_tx_valid(net_tx_valid), .net_tx_ready(net_tx_ready), .net_tx_pack(net_tx_pack),
    .net_rx_valid(net_rx_valid), .net_rx_ready(net_rx_ready), .net_rx_pack(net_rx_pack),
    .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready), .pe_rx_src(pe_rx_src),
    .pe_rx_type(pe_rx_type), .pe_rx_data(pe_rx_data),
    .err_misroute(err_misroute), .err_self(err_self), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [17:0] txq[$];
  logic [13:0] rxq[$];
  bit m_up = 0, m_es = 0, m_em = 0;
  int m_drop = 0;
  bit h_tx, h_txp, h_rx, h_rxp;
  int nd;

  function automatic bit m_tx_ready();  return m_up && (txq.size() < 8); endfunction
  function automatic bit m_rx_ready();  return m_up && (rxq.size() < 8); endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txq.delete(); rxq.delete();
      m_up = 0; m_es = 0; m_em = 0; m_drop = 0;
    end else begin
      h_tx  = pe_tx_valid && m_tx_ready();
      h_txp = (txq.size() != 0) && net_tx_ready;
      h_rx  = net_rx_valid && m_rx_ready();
      h_rxp = (rxq.size() != 0) && pe_rx_ready;
      nd = 0;
      if (h_txp) void'(txq.pop_front());
      if (h_rxp) void'(rxq.pop_front());
      if (h_tx) begin
        if (pe_tx_dest == 4'd2) begin m_es = 1; nd++; end
        else txq.push_back({4'd2, pe_tx_dest, pe_tx_type, pe_tx_data});
      end
      if (h_rx) begin
        if (net_rx_pack[13:10] != 4'd2) begin m_em = 1; nd++; end
        else rxq.push_back({net_rx_pack[17:14], net_rx_pack[9:0]});
      end
      m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
      m_up = 1;
    end
  end

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    check("pe_tx_ready",  pe_tx_ready,  m_tx_ready());
    check("net_rx_ready", net_rx_ready, m_rx_ready());
    check("net_tx_valid", net_tx_valid, txq.size() != 0);
    check("net_tx_pack",  net_tx_pack,  (txq.size() != 0) ? txq[0] : 18'd0);
    check("pe_rx_valid",  pe_rx_valid,  rxq.size() != 0);
    check("pe_rx_head",   {pe_rx_src, pe_rx_type, pe_rx_data}, (rxq.size() != 0) ? rxq[0] : 14'd0);
    check("err_self",     err_self,     m_es);
    check("err_misroute", err_misroute, m_em);
    check("drop_cnt",     drop_cnt,     m_drop);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_all_zero", {pe_tx_ready, net_tx_valid, net_tx_pack, net_rx_ready, pe_rx_valid,
                           pe_rx_src, pe_rx_type, pe_rx_data, err_misroute, err_self, drop_cnt}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    check("ready_low_at_release", pe_tx_ready, 1'b0);
    tick();
    check("tx_ready_after_release", pe_tx_ready, 1'b1);
    check("rx_ready_after_release", net_rx_ready, 1'b1);
    check("valids_idle", {net_tx_valid, pe_rx_valid}, 2'b00);

    // single TX packet
    net_tx_ready = 1; pe_tx_valid = 1; pe_tx_dest = 4'd5; pe_tx_type = 2'b01; pe_tx_data = 8'hA7;
    tick();
    pe_tx_valid = 0;
    check("tx_pkt_valid", net_tx_valid, 1'b1);
    check("tx_pkt_value", net_tx_pack, 18'b0010_0101_01_10100111);
    tick();
    check("tx_pkt_one_cycle", net_tx_valid, 1'b0);

    // fill TX FIFO, then drain with wrap
    net_tx_ready = 0;
    for (int i = 0; i < 8; i++) begin
      pe_tx_valid = 1; pe_tx_dest = 4'd5; pe_tx_type = 2'b00; pe_tx_data = 8'(i);
      tick();
    end
    pe_tx_data = 8'd8;
    check("tx_full_ready", pe_tx_ready, 1'b0);
    tick();
    check("tx_full_hold", pe_tx_ready, 1'b0);
    check("tx_full_head", net_tx_pack[7:0], 8'd0);
    net_tx_ready = 1;
    tick();
    check("tx_ready_after_pop", pe_tx_ready, 1'b1);
    check("tx_second_head", net_tx_pack[7:0], 8'd1);
    tick();
    pe_tx_valid = 0;
    repeat (8) tick();
    check("tx_drained", net_tx_valid, 1'b0);

    // RX delivery and misroute
    net_rx_valid = 1; net_rx_pack = {4'd7, 4'd2, 2'b10, 8'h3C};
    tick();
    check("rx_src",   pe_rx_src, 4'd7);
    check("rx_type",  pe_rx_type, 2'b10);
    check("rx_data",  pe_rx_data, 8'h3C);
    check("rx_valid", pe_rx_valid, 1'b1);
    net_rx_pack = {4'd7, 4'd4, 2'b10, 8'h55};
    tick();
    net_rx_valid = 0;
    check("misroute_flag", err_misroute, 1'b1);
    check("misroute_drop", drop_cnt, 8'd1);
    pe_rx_ready = 1;
    tick();
    check("rx_nothing_more", pe_rx_valid, 1'b0);
    pe_rx_ready = 0;

    // simultaneous TX self-drop and RX misroute, then saturation
    pe_tx_valid = 1; pe_tx_dest = 4'd2; pe_tx_data = 8'h11;
    net_rx_valid = 1; net_rx_pack = {4'd1, 4'd9, 2'b00, 8'h22};
    tick();
    check("self_flag", err_self, 1'b1);
    check("double_drop", drop_cnt, 8'd3);
    repeat (130) tick();
    check("drop_saturated", drop_cnt, 8'd255);
    tick();
    pe_tx_valid = 0; net_rx_valid = 0;
    tick();
    check("drop_stays", drop_cnt, 8'd255);

    // reset with queued traffic and handshakes pending
    net_tx_ready = 0; pe_rx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      pe_tx_valid = 1; pe_tx_dest = 4'd6; pe_tx_data = 8'(16 + i);
      tick();
    end
    pe_tx_valid = 0;
    for (int i = 0; i < 2; i++) begin
      net_rx_valid = 1; net_rx_pack = {4'd3, 4'd2, 2'b01, 8'(32 + i)};
      tick();
    end
    pe_tx_valid = 1; pe_tx_data = 8'h99;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valids", {net_tx_valid, pe_rx_valid}, 2'b00);
    check("midrst_flags", {err_self, err_misroute, drop_cnt}, 10'd0);
    tick(); tick();
    pe_tx_valid = 0; net_rx_valid = 0;
    rst_n = 1'b1;
    net_tx_ready = 1; pe_rx_ready = 1;
    repeat (4) tick();
    check("no_stale_tx", net_tx_valid, 1'b0);
    check("no_stale_rx", pe_rx_valid, 1'b0);

    // mixed concurrent traffic with varying back-pressure
    for (int i = 0; i < 60; i++) begin
      pe_tx_valid  = (i % 4 != 3);
      pe_tx_dest   = (i % 11 == 5) ? 4'd2 : 4'd7;
      pe_tx_type   = 2'(i);
      pe_tx_data   = 8'(i * 5);
      net_tx_ready = (i % 3 != 0) && (i < 20 || i > 35);
      net_rx_valid = (i % 5 != 4);
      net_rx_pack  = {4'(i % 16), (i % 7 == 3) ? 4'd9 : 4'd2, 2'(i + 1), 8'(i * 3)};
      pe_rx_ready  = (i % 4 < 2) && (i < 15 || i > 40);
      tick();
    end
    pe_tx_valid = 0; net_rx_valid = 0; net_tx_ready = 1; pe_rx_ready = 1;
    repeat (12) tick();
    check("mixed_tx_empty", net_tx_valid, 1'b0);
    check("mixed_rx_empty", pe_rx_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_leaf_ni.md
Name: noc_leaf_ni

Overview:
- Clocked leaf network interface between one processing element (PE) and the leaf port of a NoC router tree.
- TX path: packs PE requests (dest, type, data) into 18-bit packets stamped with NODE_ADDR, buffers them in a FIFO and offers them to the router leaf input.
- RX path: accepts packets from the router leaf output, checks the receiver address, and buffers matching packets for the PE. Misrouted packets are dropped and counted.

Parameters:
- NODE_ADDR, 2, this leaf's 4-bit network address.
- WIDTH_pack, 18, packet width.
- WIDTH_add, 4, address field width.
- WIDTH_type, 2, type field width.
- WIDTH_data, 8, payload width.
- TX_DEPTH, 8, TX FIFO entries (any value ≥2).
- RX_DEPTH, 8, RX FIFO entries (any value ≥2).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pe_tx_valid  in  1  PE request valid
- pe_tx_ready  out  1  TX FIFO can accept
- pe_tx_dest  in  4  destination address
- pe_tx_type  in  2  packet type
- pe_tx_data  in  8  payload
- net_tx_valid  out  1  packet available to router
- net_tx_ready  in  1  router accepts
- net_tx_pack  out  18  packet to router
- net_rx_valid  in  1  packet from router valid
- net_rx_ready  out  1  RX side can accept
- net_rx_pack  in  18  packet from router
- pe_rx_valid  out  1  delivered packet valid
- pe_rx_ready  in  1  PE accepts
- pe_rx_src  out  4  sender address
- pe_rx_type  out  2  packet type
- pe_rx_data  out  8  payload
- err_misroute  out  1  sticky: a packet with a foreign receiver address arrived
- err_self  out  1  sticky: PE requested dest == NODE_ADDR
- drop_cnt  out  8  count of dropped packets, saturating

Behaviour:
- Packet format, fixed: [17:14] sender addr, [13:10] receiver addr, [9:8] type, [7:0] data.
- Handshakes: a transfer occurs at a rising edge where valid && ready. Once raised, valid is held with stable data until the transfer. ready may depend only on registered state, never combinationally on valid.
- Reset (rst_n low, asynchronous, including mid-transfer):
  - Both FIFOs emptied; pointers and counts go to 0; in-flight contents are discarded.
  - Outputs: pe_tx_ready=0, net_tx_valid=0, net_tx_pack=0, net_rx_ready=0, pe_rx_valid=0, pe_rx_src/type/data=0, err_misroute=0, err_self=0, drop_cnt=0.
  - Readys rise in the first cycle after rst_n deasserts, since the FIFOs are empty.
- TX FIFO:
  - Circular buffer with head/tail pointers wrapping explicitly at TX_DEPTH-1 → 0, plus an occupancy count.
  - pe_tx_ready = (count != TX_DEPTH).
  - Push on PE transfer: entry = {NODE_ADDR, pe_tx_dest, pe_tx_type, pe_tx_data}.
  - If pe_tx_dest == NODE_ADDR: the request is accepted (handshake completes) but not pushed; err_self is set and drop_cnt increments.
  - net_tx_valid = (count != 0); net_tx_pack = entry at head (show-ahead). Pop on net transfer.
  - Latency: a PE transfer at edge N into an empty FIFO gives net_tx_valid=1 with that packet during cycle N→N+1.
  - Simultaneous push and pop: count unchanged; both pointers advance. When full, only a pop can occur in that cycle; pe_tx_ready rises the cycle after the pop.
  - Order is strictly FIFO.
- RX path:
  - net_rx_ready = (rx count != RX_DEPTH).
  - On transfer, if receiver field == NODE_ADDR, push {sender, type, data}.
  - Otherwise the packet is consumed and not pushed; err_misroute is set and drop_cnt increments.
  - pe_rx_valid = (rx count != 0); pe_rx_* show the head entry. Pop on PE transfer.
  - Same latency, wrap-around, full/empty and simultaneous push/pop rules as TX.
- drop_cnt:
  - Increments by 1 per dropped event, saturating at 255.
  - A TX drop and an RX drop in the same cycle increment it by 2 (still saturating).
- err_misroute and err_self clear only on reset.
- No combinational path from net_* inputs to pe_* outputs or vice versa.

Test Plan:
- Reset then idle → all outputs 0 during reset; pe_tx_ready=1 and net_rx_ready=1 one cycle after release; valids stay 0.
- NODE_ADDR=2, PE sends dest=5, type=01, data=0xA7 with net_tx_ready=1 → next cycle net_tx_pack=18'b0010_0101_01_10100111, net_tx_valid=1 for exactly one cycle.
- net_tx_ready=0, PE pushes 9 packets (data 0..8) → the 8th push fills the FIFO and pe_tx_ready=0 on the 9th. Release ready → packets 0..7 emerge in order over 8 consecutive cycles (wrap-around covered); pe_tx_ready returns after the first pop.
- Router delivers receiver=2 src=7 type=10 data=0x3C → pe_rx_src=7, pe_rx_type=10, pe_rx_data=0x3C, pe_rx_valid=1. A second packet with receiver=4 → err_misroute=1, drop_cnt=1, nothing delivered.
- PE dest=2 (self) and a misrouted RX packet in the same cycle → err_self=1, err_misroute=1, drop_cnt +2. Preload drop_cnt to 255 via repeated drops → it stays 255.
- Assert rst_n low with 3 TX and 2 RX entries queued, mid-handshake → immediately all valids 0, counts 0; after release no stale packet appears.
